// File: rtl/raspi_link_pkg.sv
// Shared constants and types for the Raspberry Pi parallel-bus link.
package raspi_link_pkg;

    localparam logic [8:0] ESC_WORD        = 9'h1ff;
    localparam logic [7:0] CHAN_NONE       = 8'hff;
    localparam logic [7:0] SYNC_LINK_RESET = 8'hff;
    localparam logic [7:0] SYNC_DEBUG      = 8'h00;
    localparam logic [8:0] IDLE_WORD       = 9'h1ff;

    // Write-stream decoder state: DEC_ESC means the previous word was an escape.
    typedef enum logic {
        DEC_IDLE = 1'b0,
        DEC_ESC  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/raspi_link_fifo.sv
// Synchronous FIFO with combinational head output and a flush that empties it.
module raspi_link_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/raspi_link.sv
// Pin-level transceiver for the 9-bit Raspberry Pi bus: synchronises the pins,
// decodes host writes into a channel-tagged RX stream and serves reads from a TX FIFO.
module raspi_link
    import raspi_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       raspi_clk_i,
    input  logic       raspi_dir_i,
    input  logic [8:0] raspi_dat_i,
    output logic [8:0] raspi_dat_o,
    output logic       raspi_dat_oe,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_chan,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [8:0] tx_data,
    output logic       sync_valid,
    output logic [7:0] sync_code,
    output logic       overflow
);

    // Valid/ready: a word moves on any clk edge where valid && ready are both high;
    // the offering side holds its word stable until that edge.

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic [8:0]             dat_sync [SYNC_STAGES];
    logic                   clk_s, dir_s, clk_prev, armed;
    logic [8:0]             dat_s;
    logic                   edge_det, wr_edge, rd_edge;

    dec_state_t dec_state, dec_state_nxt;
    logic [7:0] chan, chan_nxt;
    logic       sync_fire, rx_push, rx_flush, ovf_set, ovf_clr;

    logic [15:0] rx_head;
    logic        rx_full, rx_empty;
    logic [8:0]  tx_head;
    logic        tx_full, tx_empty;

    // Strobe chain resets high so a strobe held through reset never looks like an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dir_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) dat_sync[i] <= '0;
            clk_prev <= 1'b1;
            armed    <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], raspi_clk_i};
            dir_sync    <= {dir_sync[SYNC_STAGES-2:0], raspi_dir_i};
            dat_sync[0] <= raspi_dat_i;
            for (int i = 1; i < SYNC_STAGES; i++) dat_sync[i] <= dat_sync[i-1];
            clk_prev    <= clk_s;
            armed       <= armed | ~clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dir_s    = dir_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign edge_det = armed && clk_s && !clk_prev;
    assign wr_edge  = edge_det && dir_s;
    assign rd_edge  = edge_det && !dir_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dec_state <= DEC_IDLE;
            chan      <= CHAN_NONE;
        end else begin
            dec_state <= dec_state_nxt;
            chan      <= chan_nxt;
        end
    end

    always_comb begin
        dec_state_nxt = dec_state;
        chan_nxt      = chan;
        sync_fire     = 1'b0;
        rx_push       = 1'b0;
        rx_flush      = 1'b0;
        ovf_set       = 1'b0;
        ovf_clr       = 1'b0;
        if (wr_edge) begin
            if (dec_state == DEC_ESC && !dat_s[8]) begin
                sync_fire     = 1'b1;
                chan_nxt      = CHAN_NONE;
                dec_state_nxt = DEC_IDLE;
                if (dat_s[7:0] == SYNC_LINK_RESET) begin
                    ovf_clr  = 1'b1;
                    rx_flush = 1'b1;
                end
            end else if (dat_s == ESC_WORD) begin
                dec_state_nxt = DEC_ESC;
            end else if (dat_s[8]) begin
                chan_nxt      = dat_s[7:0];
                dec_state_nxt = DEC_IDLE;
            end else if (chan != CHAN_NONE) begin
                if (rx_full) ovf_set = 1'b1;
                else         rx_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_valid   <= 1'b0;
            sync_code    <= '0;
            overflow     <= 1'b0;
            raspi_dat_oe <= 1'b0;
            raspi_dat_o  <= IDLE_WORD;
        end else begin
            sync_valid   <= sync_fire;
            if (sync_fire) sync_code <= dat_s[7:0];
            if (ovf_clr)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
            raspi_dat_oe <= !dir_s;
            raspi_dat_o  <= tx_empty ? IDLE_WORD : tx_head;
        end
    end

    raspi_link_fifo #(.WIDTH(16), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .flush (rx_flush),
        .push  (rx_push),
        .wdata ({chan, dat_s[7:0]}),
        .pop   (rx_valid && rx_ready),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign rx_chan  = rx_head[15:8];
    assign rx_data  = rx_head[7:0];

    raspi_link_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .flush (1'b0),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (rd_edge),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_ready = !tx_full;

endmodule

// File: tb/tb_raspi_link.sv
// Directed bench for raspi_link: drives host bus transfers and checks RX stream,
// sync pulses, TX readback, overflow and strobe-through-reset behaviour.
module tb_raspi_link;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       raspi_clk_i = 1'b0;
    logic       raspi_dir_i = 1'b1;
    logic [8:0] raspi_dat_i = '0;
    logic [8:0] raspi_dat_o;
    logic       raspi_dat_oe;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_chan;
    logic [7:0] rx_data;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [8:0] tx_data = '0;
    logic       sync_valid;
    logic [7:0] sync_code;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int sync_cnt = 0;
    logic [7:0]  last_sync = '0;
    logic [15:0] exp_q[$];

    raspi_link dut (
        .clk          (clk),
        .resetn       (resetn),
        .raspi_clk_i  (raspi_clk_i),
        .raspi_dir_i  (raspi_dir_i),
        .raspi_dat_i  (raspi_dat_i),
        .raspi_dat_o  (raspi_dat_o),
        .raspi_dat_oe (raspi_dat_oe),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_chan      (rx_chan),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .sync_valid   (sync_valid),
        .sync_code    (sync_code),
        .overflow     (overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic host_write(input logic [8:0] w);
        raspi_dir_i = 1'b1;
        raspi_dat_i = w;
        wait_cycles(4);
        raspi_clk_i = 1'b1;
        wait_cycles(5);
        raspi_clk_i = 1'b0;
        wait_cycles(5);
    endtask

    task automatic host_read(output logic [8:0] v);
        raspi_dir_i = 1'b0;
        wait_cycles(4);
        check("read_oe", raspi_dat_oe, 1);
        v = raspi_dat_o;
        raspi_clk_i = 1'b1;
        wait_cycles(5);
        raspi_clk_i = 1'b0;
        wait_cycles(5);
    endtask

    task automatic tx_push(input logic [8:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        wait_cycles(1);
        tx_valid = 1'b0;
    endtask

    // scoreboard: each accepted RX word must match the head of exp_q
    always @(negedge clk) begin
        if (resetn) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("rx_unexpected", {rx_chan, rx_data}, 32'h1_0000);
                else                   check("rx_word", {rx_chan, rx_data}, exp_q.pop_front());
            end
            if (sync_valid) begin
                sync_cnt++;
                last_sync = sync_code;
            end
        end
    end

    initial begin
        logic [8:0] v;
        int         s0;
        logic [15:0] head0;

        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_oe", raspi_dat_oe, 0);
        check("rst_dat_o", raspi_dat_o, 9'h1ff);
        check("rst_sync_valid", sync_valid, 0);
        check("rst_sync_code", sync_code, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_ready", tx_ready, 1);

        // read with empty TX FIFO
        host_read(v);
        check("read_empty", v, 9'h1ff);
        check("read_empty_rx", rx_valid, 0);

        // escape, link reset, channel 0, two data bytes
        s0 = sync_cnt;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0041);
        host_write(9'h1ff);
        host_write(9'h0ff);
        host_write(9'h100);
        host_write(9'h040);
        host_write(9'h041);
        wait_cycles(4);
        check("sync_count_a", sync_cnt - s0, 1);
        check("sync_code_a", last_sync, 8'hff);
        check("rx_pending_a", exp_q.size(), 0);

        // TX readback
        tx_push(9'h100);
        tx_push(9'h0a7);
        host_read(v);
        check("tx_read0", v, 9'h100);
        host_read(v);
        check("tx_read1", v, 9'h0a7);
        host_read(v);
        check("tx_read2", v, 9'h1ff);
        check("tx_ready_end", tx_ready, 1);

        // fill RX FIFO with consumer stalled; 17th word overflows
        rx_ready = 1'b0;
        host_write(9'h100);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({8'h00, 8'(i)});
            host_write({1'b0, 8'(i + 8'h10)});
        end
        // expected payloads are i+0x10
        for (int i = 0; i < 16; i++) exp_q[i] = {8'h00, 8'(i + 8'h10)};
        check("ovf_set", overflow, 1);
        check("ovf_rx_valid", rx_valid, 1);
        head0 = {rx_chan, rx_data};
        check("stall_head", head0, 16'h0010);
        wait_cycles(3);
        check("stall_hold", {rx_chan, rx_data}, head0);
        rx_ready = 1'b1;
        wait_cycles(20);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_sticky", overflow, 1);

        // words left in the FIFO are discarded by the link-reset sync
        rx_ready = 1'b0;
        host_write(9'h055);
        host_write(9'h066);
        check("pre_flush_valid", rx_valid, 1);
        host_write(9'h1ff);
        host_write(9'h0ff);
        wait_cycles(2);
        check("flush_ovf", overflow, 0);
        check("flush_rx_valid", rx_valid, 0);
        rx_ready = 1'b1;

        // data with channel NONE is dropped silently
        host_write(9'h1ff);
        host_write(9'h0ff);
        host_write(9'h005);
        wait_cycles(4);
        check("none_rx_valid", rx_valid, 0);
        check("none_ovf", overflow, 0);

        // repeated escape then sync 00
        s0 = sync_cnt;
        host_write(9'h1ff);
        host_write(9'h1ff);
        host_write(9'h000);
        wait_cycles(2);
        check("sync_count_b", sync_cnt - s0, 1);
        check("sync_code_b", last_sync, 8'h00);
        check("sync_code_port", sync_code, 8'h00);

        // strobe held high through reset: an escape there must not be decoded
        s0 = sync_cnt;
        raspi_dir_i = 1'b1;
        raspi_dat_i = 9'h1ff;
        wait_cycles(4);
        raspi_clk_i = 1'b1;
        wait_cycles(1);
        resetn = 1'b0;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(8);
        raspi_clk_i = 1'b0;
        wait_cycles(5);
        host_write(9'h000);
        wait_cycles(2);
        check("rst_strobe_nosync", sync_cnt - s0, 0);
        check("rst_strobe_rx", rx_valid, 0);
        host_write(9'h1ff);
        host_write(9'h0aa);
        wait_cycles(2);
        check("post_rst_sync", sync_cnt - s0, 1);
        check("post_rst_code", last_sync, 8'haa);
        check("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
